// File: rtl/pcie_phy_pkg.sv
// Shared constants and types for the byte-lane PHY blocks.
package pcie_phy_pkg;

  localparam int BYTE_W   = 8;
  localparam int NBYTES   = 4;
  localparam int LAST_IDX = NBYTES - 1;

  typedef logic [1:0] byte_idx_t;

endpackage

// File: rtl/mux_8_32.sv
// Byte-to-word packer: assembles bytes MSB-first into a word with a one-cycle valid strobe
// and an sof input that realigns the lane by discarding any partial word.
module mux_8_32
  import pcie_phy_pkg::*;
(
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic                     sof_in,
  output logic [BYTE_W*NBYTES-1:0] data_out,
  output logic                     valid_out,
  output byte_idx_t                byte_idx,
  output logic                     align_err
);

  localparam int SHIFT_W = BYTE_W * (NBYTES - 1);
  localparam int WORD_W  = BYTE_W * NBYTES;

  byte_idx_t          idx_q, idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0]  word_d;
  logic               valid_d;
  logic               align_d;

  // The byte index is the state; only accepted bytes move it.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = data_out;
    valid_d = 1'b0;
    align_d = 1'b0;
    if (valid_in) begin
      if (sof_in && (idx_q != byte_idx_t'(0))) begin
        shift_d = {{(SHIFT_W-BYTE_W){1'b0}}, data_in};
        idx_d   = byte_idx_t'(1);
        align_d = 1'b1;
      end else if (idx_q == byte_idx_t'(LAST_IDX)) begin
        word_d  = {shift_q, data_in};
        valid_d = 1'b1;
        idx_d   = byte_idx_t'(0);
        shift_d = '0;
      end else begin
        shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], data_in};
        idx_d   = byte_idx_t'(idx_q + byte_idx_t'(1));
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      idx_q     <= byte_idx_t'(0);
      shift_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      align_err <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_out  <= word_d;
      valid_out <= valid_d;
      align_err <= align_d;
    end
  end

  assign byte_idx = idx_q;

endmodule
